// File: rtl/axil_arb_pkg.sv
// Shared FSM state type, AXI response codes and pointer-width helper for the
// AXI4-Lite master arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Never returns 0, so a pointer bus is always at least one bit wide.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping past N-1. The pointer register lives in the parent.
module rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Round-robin share of one AXI4-Lite master port among C_NUM_REQ cmd/rsp requesters,
// one transaction in flight. Define AXIL_ARB_TIMEOUT_EN to add a SLVERR watchdog.
module axi_lite_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter  int C_NUM_REQ          = 4,
  parameter  int C_M_AXI_ADDR_WIDTH = 32,
  parameter  int C_M_AXI_DATA_WIDTH = 32,
  parameter  int C_TIMEOUT_CYCLES   = 256,
  localparam int PW                 = ptr_width(C_NUM_REQ)
) (
  input  logic                                     M_AXI_ACLK,
  input  logic                                     M_AXI_ARESET,
  input  logic [C_NUM_REQ-1:0]                     req_valid,
  output logic [C_NUM_REQ-1:0]                     req_ready,
  input  logic [C_NUM_REQ-1:0]                     req_write,
  input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]  req_addr,
  input  logic [C_NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]  req_wdata,
  input  logic [C_NUM_REQ*C_M_AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic [C_NUM_REQ-1:0]                     rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                               rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
  output logic [2:0]                               M_AXI_AWPROT,
  output logic                                     M_AXI_AWVALID,
  input  logic                                     M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
  output logic                                     M_AXI_WVALID,
  input  logic                                     M_AXI_WREADY,
  input  logic [1:0]                               M_AXI_BRESP,
  input  logic                                     M_AXI_BVALID,
  output logic                                     M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic [2:0]                               M_AXI_ARPROT,
  output logic                                     M_AXI_ARVALID,
  input  logic                                     M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                               M_AXI_RRESP,
  input  logic                                     M_AXI_RVALID,
  output logic                                     M_AXI_RREADY,
  output logic [2:0]                               dbg_state_o,
  output logic [PW-1:0]                            dbg_ptr_o
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  // Handshake contract on every channel: a transfer happens on a rising edge
  // where VALID and READY are both 1; VALID and its payload never change while
  // VALID is high and READY low. req_ready/rsp_valid follow the same rule, and
  // rsp_valid is a one-cycle pulse that cannot be stalled.

  state_e             state_q;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      gnt_idx_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [SW-1:0]      wstrb_q;
  logic               awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [DW-1:0]      rdata_q;
  logic [1:0]         resp_q;
  logic [C_NUM_REQ-1:0] rsp_valid_q;
  logic [DW-1:0]      rsp_rdata_q;
  logic [1:0]         rsp_resp_q;

  logic [C_NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               cmd_write;
  logic [AW-1:0]      cmd_addr;
  logic [DW-1:0]      cmd_wdata;
  logic [SW-1:0]      cmd_wstrb;
  logic               aw_done, w_done, adv, tmo_hit;

  rr_arbiter #(.N(C_NUM_REQ)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (gnt[i]) begin
        cmd_write = req_write[i];
        cmd_addr  = req_addr[i*AW +: AW];
        cmd_wdata = req_wdata[i*DW +: DW];
        cmd_wstrb = req_wstrb[i*SW +: SW];
      end
    end
  end

  assign ptr_d   = (gnt_idx == PW'(C_NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q || M_AXI_WREADY;

  // adv: the current state's exit condition is met this cycle.
  always_comb begin
    adv = 1'b0;
    unique case (state_q)
      IDLE:    adv = |gnt;
      WR_AW_W: adv = aw_done && w_done;
      WR_B:    adv = M_AXI_BVALID;
      RD_AR:   adv = M_AXI_ARREADY;
      RD_R:    adv = M_AXI_RVALID;
      RSP:     adv = 1'b1;
      default: adv = 1'b1;
    endcase
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  logic          waiting;

  assign waiting = (state_q == WR_AW_W) || (state_q == WR_B) ||
                   (state_q == RD_AR) || (state_q == RD_R);
  // Fires on the last allowed waiting cycle, so VALID/READY stay up exactly C_TIMEOUT_CYCLES.
  assign tmo_hit = waiting && !adv && (tmr_q == TW'(C_TIMEOUT_CYCLES - 1));

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET || !waiting || adv || tmo_hit) tmr_q <= '0;
    else                                            tmr_q <= tmr_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      rsp_valid_q <= '0;
      if (tmo_hit) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        rdata_q   <= '0;
        resp_q    <= RESP_SLVERR;
        state_q   <= RSP;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (adv) begin
              gnt_idx_q <= gnt_idx;
              ptr_q     <= ptr_d;
              addr_q    <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              rdata_q   <= '0;
              resp_q    <= RESP_OKAY;
              if (cmd_write) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= WR_AW_W;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= RD_AR;
              end
            end
          end
          WR_AW_W: begin
            if (M_AXI_AWREADY) awvalid_q <= 1'b0;
            if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
            if (adv) begin
              bready_q <= 1'b1;
              state_q  <= WR_B;
            end
          end
          WR_B: begin
            if (adv) begin
              bready_q <= 1'b0;
              resp_q   <= M_AXI_BRESP;
              state_q  <= RSP;
            end
          end
          RD_AR: begin
            if (adv) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= RD_R;
            end
          end
          RD_R: begin
            if (adv) begin
              rready_q <= 1'b0;
              rdata_q  <= M_AXI_RDATA;
              resp_q   <= M_AXI_RRESP;
              state_q  <= RSP;
            end
          end
          RSP: begin
            rsp_valid_q <= {{(C_NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_q;
            rsp_rdata_q <= rdata_q;
            rsp_resp_q  <= resp_q;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Grants are only offered while idle and out of reset; the one-hot comes straight from the picker.
  assign req_ready     = (state_q == IDLE && !M_AXI_ARESET) ? gnt : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign dbg_state_o   = state_q;
  assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Bench for axi_lite_master_arbiter: vector table of single transactions against a
// small AXI4-Lite slave model, plus round-robin, reset-abort and watchdog sequences.
module tb_axi_lite_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]      req_valid = '0, req_write = '0;
  logic [N*AW-1:0]   req_addr  = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N*DW/8-1:0] req_wstrb = '0;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     m_awaddr, m_araddr;
  logic [2:0]        m_awprot, m_arprot;
  logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic              s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0;
  logic [1:0]        s_bresp = 0, s_rresp = 0;
  logic [DW-1:0]     s_rdata = 0;
  logic [2:0]        dbg_state;
  logic [1:0]        dbg_ptr;

  axi_lite_master_arbiter #(
    .C_NUM_REQ(N), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(s_wready),
    .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(m_bready),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(m_rready),
    .dbg_state_o(dbg_state), .dbg_ptr_o(dbg_ptr)
  );

  // ---------------- slave model ----------------
  // Acts 2 ns after each falling edge: first retires the handshakes that happened
  // at the preceding rising edge, then sets READY/VALID for the next one.
  int aw_dly = 0, w_dly = 0;
  logic ar_block = 0, r_hold = 0;
  logic [31:0] mem [64];
  int aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n, aw_cyc, w_cyc;
  int outst = 0, max_out = 0;

  initial begin
    logic p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, r_pend;
    logic [31:0] pa_addr, pr_addr, pw_data, aw_l, wd_l;
    logic [3:0]  pw_strb, ws_l;
    int aw_wait, w_wait;
    p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; aw_got = 0; w_got = 0; r_pend = 0;
    pa_addr = 0; pr_addr = 0; pw_data = 0; pw_strb = 0; aw_l = 0; wd_l = 0; ws_l = 0;
    aw_wait = 0; w_wait = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; aw_got = 0; w_got = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; outst = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
      end else begin
        if (p_aw) begin aw_got = 1; aw_l = pa_addr; aw_hs_n++; outst++; end
        if (p_w)  begin w_got = 1; wd_l = pw_data; ws_l = pw_strb; w_hs_n++; end
        if (p_b)  begin s_bvalid = 0; aw_got = 0; w_got = 0; b_hs_n++; outst--; end
        if (p_ar) begin
          ar_hs_n++; outst++; r_pend = 1;
          s_rdata = (pr_addr < 32'h100) ? mem[pr_addr[7:2]] : 32'hDEAD_BEEF;
        end
        if (p_r)  begin r_pend = 0; r_hs_n++; outst--; end
        if (outst > max_out) max_out = outst;
        if (aw_got && w_got && !s_bvalid) begin
          if (aw_l < 32'h100)
            for (int b = 0; b < 4; b++)
              if (ws_l[b]) mem[aw_l[7:2]][b*8 +: 8] = wd_l[b*8 +: 8];
          s_bresp  = (aw_l == 32'h0100_0000) ? 2'b10 : 2'b00;
          s_bvalid = 1;
        end
        if (m_awvalid) aw_cyc++;
        if (m_wvalid)  w_cyc++;
        if (m_awvalid && !aw_got) begin
          s_awready = (aw_wait >= aw_dly); if (!s_awready) aw_wait++;
        end else begin s_awready = 0; aw_wait = 0; end
        if (m_wvalid && !w_got) begin
          s_wready = (w_wait >= w_dly); if (!s_wready) w_wait++;
        end else begin s_wready = 0; w_wait = 0; end
        s_arready = m_arvalid && !r_pend && !ar_block;
        s_rvalid  = r_pend && !r_hold;
        p_aw = m_awvalid && s_awready; pa_addr = m_awaddr;
        p_w  = m_wvalid && s_wready;   pw_data = m_wdata; pw_strb = m_wstrb;
        p_b  = s_bvalid && m_bready;
        p_ar = m_arvalid && s_arready; pr_addr = m_araddr;
        p_r  = s_rvalid && m_rready;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int pass_cnt = 0, total_cnt = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_resp, m_awvalid, m_wvalid, m_bready,
                          m_arvalid, m_rready}, 64'h0);
    check({tag, "_rdata"}, rsp_rdata, 64'h0);
    check({tag, "_state"}, dbg_state, 64'h0);
    check({tag, "_ptr"}, dbg_ptr, 64'h0);
  endtask

  // ---------------- driver tasks ----------------
  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          awd, wd;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int          e_lat;   // 0: latency not checked
    int          e_awc, e_wc;
  } vec_t;

  task automatic wait_ready(output int n);
    n = 0;
    while (!(|req_ready) && n < 50) begin @(negedge clk); #1; n++; end
  endtask

  task automatic wait_rsp(output int t);
    t = 1;
    while (!(|rsp_valid) && t < 200) begin @(negedge clk); #1; t++; end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n, t;
    logic [3:0] oh;
    oh = 4'b0001 << v.req;
    aw_dly = v.awd; w_dly = v.wd;
    aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0; aw_cyc = 0; w_cyc = 0;
    @(negedge clk);
    req_write[v.req] = v.wr;
    req_addr[v.req*AW +: AW] = v.addr;
    req_wdata[v.req*DW +: DW] = v.wdata;
    req_wstrb[v.req*4 +: 4] = v.strb;
    req_valid[v.req] = 1'b1;
    #1;
    wait_ready(n);
    check($sformatf("v%0d_grant", k), req_ready, oh);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp(t);
    if (v.e_lat != 0) check($sformatf("v%0d_latency", k), t, v.e_lat);
    check($sformatf("v%0d_rsp_valid", k), rsp_valid, oh);
    check($sformatf("v%0d_resp", k), rsp_resp, v.e_resp);
    check($sformatf("v%0d_rdata", k), rsp_rdata, v.e_rdata);
    @(negedge clk); #1;
    check($sformatf("v%0d_rsp_pulse", k), rsp_valid, 0);
    check($sformatf("v%0d_handshakes", k), {aw_hs_n[3:0], w_hs_n[3:0], b_hs_n[3:0], ar_hs_n[3:0],
          r_hs_n[3:0]}, v.wr ? 64'h11100 : 64'h00011);
    check($sformatf("v%0d_aw_cycles", k), aw_cyc, v.e_awc);
    check($sformatf("v%0d_w_cycles", k), w_cyc, v.e_wc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[10];
    int n, t, g;
    logic [31:0] rr_rd[4];

    //        req wr  addr           wdata         strb    awd wd resp   rdata         lat awc wc
    vecs[0] = '{0, 1, 32'h08,        32'hAA00_0055, 4'b1001, 0, 0, 2'b00, 32'h0,         4, 1, 1};
    vecs[1] = '{0, 0, 32'h08,        32'h0,         4'b0000, 0, 0, 2'b00, 32'hAA00_0055, 4, 0, 0};
    vecs[2] = '{1, 1, 32'h10,        32'h1234_5678, 4'b1111, 3, 0, 2'b00, 32'h0,         0, 4, 1};
    vecs[3] = '{2, 1, 32'h14,        32'hCAFE_BABE, 4'b1111, 0, 3, 2'b00, 32'h0,         0, 1, 4};
    vecs[4] = '{1, 0, 32'h10,        32'h0,         4'b0000, 0, 0, 2'b00, 32'h1234_5678, 4, 0, 0};
    vecs[5] = '{2, 0, 32'h14,        32'h0,         4'b0000, 0, 0, 2'b00, 32'hCAFE_BABE, 4, 0, 0};
    vecs[6] = '{3, 1, 32'h0100_0000, 32'h5555_5555, 4'b1111, 0, 0, 2'b10, 32'h0,         4, 1, 1};
    vecs[7] = '{3, 0, 32'h0C,        32'h0,         4'b0000, 0, 0, 2'b00, 32'h1000_0003, 4, 0, 0};
    vecs[8] = '{1, 1, 32'h18,        32'hFFFF_FFFF, 4'b0011, 2, 2, 2'b00, 32'h0,         0, 3, 3};
    vecs[9] = '{2, 0, 32'h18,        32'h0,         4'b0000, 0, 0, 2'b00, 32'h1000_FFFF, 4, 0, 0};

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

    // Reset while waiting for R: abort without a response and clear the pointer.
    r_hold = 1'b1;
    @(negedge clk);
    req_write[2] = 1'b0; req_addr[2*AW +: AW] = 32'h0C; req_valid[2] = 1'b1;
    #1;
    wait_ready(n);
    check("abort_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    n = 0;
    while (dbg_state != 3'd4 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    check("abort_in_rd_r", dbg_state, 3'd4);
    check("abort_rready", m_rready, 1'b1);
    check("abort_ptr_before", dbg_ptr, 2'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0; r_hold = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); #1; if (|rsp_valid) n++; end
    check("abort_no_rsp", n, 0);

    // Round-robin: everyone asks at once, requester 0 asks twice.
    rr_rd = '{32'h1000_0000, 32'h1000_0001, 32'hAA00_0055, 32'h1000_0003};
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*AW +: AW] = 32'(i * 4);
    end
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      wait_ready(n);
      check($sformatf("rr_grant%0d", k), req_ready, e);
      g = (e == 4'b0001) ? 0 : (e == 4'b0010) ? 1 : (e == 4'b0100) ? 2 : 3;
      @(negedge clk);
      if (k != 0) req_valid[g] = 1'b0;
      #1;
      wait_rsp(t);
      check($sformatf("rr_rsp%0d", k), rsp_valid, e);
      check($sformatf("rr_rdata%0d", k), rsp_rdata, rr_rd[g]);
    end
    check("max_outstanding", max_out, 1);

    // Slave never accepts AR.
    ar_block = 1'b1;
    @(negedge clk);
    req_write[1] = 1'b0; req_addr[1*AW +: AW] = 32'h04; req_valid[1] = 1'b1;
    #1;
    wait_ready(n);
    check("stall_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    n = 0;
    while (m_arvalid && n < 40) begin n++; @(negedge clk); #1; end
`ifdef AXIL_ARB_TIMEOUT_EN
    check("tmo_arvalid_cycles", n, 16);
    wait_rsp(t);
    check("tmo_rsp_valid", rsp_valid, 4'b0010);
    check("tmo_resp", rsp_resp, 2'b10);
    check("tmo_rdata", rsp_rdata, 32'h0);
    ar_block = 1'b0;
`else
    check("stall_arvalid_cycles", n, 40);
    check("stall_arvalid_held", m_arvalid, 1'b1);
    ar_block = 1'b0;
    wait_rsp(t);
    check("stall_rsp_valid", rsp_valid, 4'b0010);
    check("stall_resp", rsp_resp, 2'b00);
    check("stall_rdata", rsp_rdata, 32'h1000_0001);
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
